// File: rtl/draw_scheduler.sv
// Purpose : round-robin scheduler that rasterises rectangles from 4 requesters and full-screen clears into a pixel stream.
// Latency : first pixel one cycle after accept (or clear entry), then one pixel per cycle; back to IDLE the cycle after the last pixel.
// Backpr. : req_ready is a combinational accept strobe, offered to one requester only in IDLE with no clear pending; clears queue until IDLE.
//
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   req_valid/req_ready           per-requester handshake (4 bits each)
//   req_x/req_y/req_w/req_h       packed per-requester rectangle operands (w/h are size minus 1)
//   req_colour                    packed per-requester 3-bit fill colour
//   clear_start/clear_colour      one-cycle full-screen clear request and its colour
//   clear_done                    one-cycle pulse on the first IDLE cycle after a clear
//   plot/x/y/colour               registered pixel write port to the VGA adapter
//   busy, grant_id                activity flag and index of the current/last granted requester

module draw_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int NUM_REQ  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [15:0] req_w,
  input  logic [15:0] req_h,
  input  logic [11:0] req_colour,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic        clear_done,
  output logic        plot,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        busy,
  output logic [1:0]  grant_id
);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR} state_t;

  // 9-bit limits so that a carry out of the 8-bit sum lands above the limit
  // and is clipped by the same compare as an off-screen coordinate.
  localparam logic [8:0] SW9     = 9'(SCREEN_W);
  localparam logic [8:0] SH9     = 9'(SCREEN_H);
  localparam logic [7:0] LAST_CX = 8'(SCREEN_W - 1);
  localparam logic [7:0] LAST_CY = 8'(SCREEN_H - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic        clear_pending;
  logic [2:0]  clr_col;

  // latched rectangle
  logic [7:0]  x0_q;
  logic [7:0]  y0_q;
  logic [3:0]  w_q;
  logic [3:0]  h_q;
  logic [2:0]  col_q;

  // raster position of the pixel currently on the output; offsets in DRAW,
  // absolute screen coordinates in CLEAR
  logic [7:0]  cnt_x;
  logic [7:0]  cnt_y;

  // round-robin winner
  logic        win_vld;
  logic [1:0]  win_id;
  logic [1:0]  cand;
  logic [7:0]  win_x;
  logic [7:0]  win_y;
  logic [3:0]  win_w;
  logic [3:0]  win_h;
  logic [2:0]  win_col;
  logic        accept_ok;

  // raster stepping
  logic        wrap_x;
  logic        last_pix;
  logic [7:0]  nxt_x;
  logic [7:0]  nxt_y;
  logic [8:0]  drw_sx;
  logic [8:0]  drw_sy;
  logic        first_on;

  // Search starts at rr_ptr; the 2-bit add wraps modulo 4 for free.
  always_comb begin
    win_vld = 1'b0;
    win_id  = rr_ptr;
    cand    = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr + 2'(k);
      if (!win_vld && req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    win_x   = '0;
    win_y   = '0;
    win_w   = '0;
    win_h   = '0;
    win_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == 2'(i)) begin
        win_x   = req_x[8*i +: 8];
        win_y   = req_y[8*i +: 8];
        win_w   = req_w[4*i +: 4];
        win_h   = req_h[4*i +: 4];
        win_col = req_colour[3*i +: 3];
      end
    end
  end

  // A clear arriving this very cycle already outranks the requesters, so it
  // blocks the grant just like a clear that is already pending.
  assign accept_ok = (state == IDLE) && !clear_pending && !clear_start && !reset && win_vld;
  assign req_ready = accept_ok ? (4'b0001 << win_id) : 4'b0000;

  always_comb begin
    if (state == CLEAR) begin
      wrap_x   = (cnt_x == LAST_CX);
      last_pix = wrap_x && (cnt_y == LAST_CY);
    end else begin
      wrap_x   = (cnt_x == {4'b0000, w_q});
      last_pix = wrap_x && (cnt_y == {4'b0000, h_q});
    end
    nxt_x = wrap_x ? 8'd0 : cnt_x + 8'd1;
    nxt_y = wrap_x ? cnt_y + 8'd1 : cnt_y;
  end

  assign drw_sx   = {1'b0, x0_q} + {1'b0, nxt_x};
  assign drw_sy   = {1'b0, y0_q} + {1'b0, nxt_y};
  assign first_on = ({1'b0, win_x} < SW9) && ({1'b0, win_y} < SH9);

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= 2'd0;
      clear_pending <= 1'b0;
      clr_col       <= 3'd0;
      x0_q          <= 8'd0;
      y0_q          <= 8'd0;
      w_q           <= 4'd0;
      h_q           <= 4'd0;
      col_q         <= 3'd0;
      cnt_x         <= 8'd0;
      cnt_y         <= 8'd0;
      plot          <= 1'b0;
      x             <= 8'd0;
      y             <= 8'd0;
      colour        <= 3'd0;
      clear_done    <= 1'b0;
      grant_id      <= 2'd0;
    end else begin
      clear_done <= 1'b0;

      // A second clear while one is queued or running is dropped.
      if (clear_start && !clear_pending && (state != CLEAR)) begin
        clear_pending <= 1'b1;
        clr_col       <= clear_colour;
      end

      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (clear_pending) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
            cnt_x         <= 8'd0;
            cnt_y         <= 8'd0;
            plot          <= 1'b1;
            x             <= 8'd0;
            y             <= 8'd0;
            colour        <= clr_col;
          end else if (accept_ok) begin
            state    <= DRAW;
            grant_id <= win_id;
            rr_ptr   <= win_id + 2'd1;
            x0_q     <= win_x;
            y0_q     <= win_y;
            w_q      <= win_w;
            h_q      <= win_h;
            col_q    <= win_col;
            cnt_x    <= 8'd0;
            cnt_y    <= 8'd0;
            // first pixel goes out straight from the request operands
            plot     <= first_on;
            x        <= win_x;
            y        <= win_y;
            colour   <= win_col;
          end
        end

        DRAW: begin
          if (last_pix) begin
            state <= IDLE;
            plot  <= 1'b0;
          end else begin
            cnt_x  <= nxt_x;
            cnt_y  <= nxt_y;
            plot   <= (drw_sx < SW9) && (drw_sy < SH9);
            x      <= drw_sx[7:0];
            y      <= drw_sy[7:0];
            colour <= col_q;
          end
        end

        CLEAR: begin
          if (last_pix) begin
            state      <= IDLE;
            plot       <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            cnt_x  <= nxt_x;
            cnt_y  <= nxt_y;
            plot   <= 1'b1;
            x      <= nxt_x;
            y      <= nxt_y;
            colour <= clr_col;
          end
        end

        default: begin
          state <= IDLE;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- NUM_REQ, 4, number of rectangle requesters (fixed at 4).

REQ-002 One clock; reset is synchronous and active-high.

REQ-003 Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- req_valid  in  4  per-requester rectangle request.
- req_ready  out  4  per-requester accept strobe.
- req_x  in  32  4x8 rectangle left x; requester i at [8i+7:8i].
- req_y  in  32  4x8 rectangle top y.
- req_w  in  16  4x4 width minus 1 (1..16 px).
- req_h  in  16  4x4 height minus 1 (1..16 px).
- req_colour  in  12  4x3 fill colour.
- clear_start  in  1  one-cycle full-screen clear request.
- clear_colour  in  3  clear fill colour, sampled with clear_start.
- clear_done  out  1  one-cycle pulse when clear finishes.
- plot  out  1  pixel write enable to the VGA adapter.
- x  out  8  pixel x.
- y  out  8  pixel y.
- colour  out  3  pixel colour.
- busy  out  1  high in DRAW or CLEAR.
- grant_id  out  2  requester index of the current or last rectangle.

Function
REQ-004 States: IDLE, DRAW, CLEAR.
REQ-005 req_ready[i] is combinational. It is high only when all hold: state==IDLE, no clear pending, req_valid[i]=1, and i is the round-robin winner. At most one bit is high at a time.
REQ-006 Round-robin: search starts at rr_ptr and wraps modulo 4; the first valid requester wins. On accept of i, rr_ptr becomes (i+1) mod 4.
REQ-007 On accept in IDLE (cycle N), x/y/w/h/colour of the winner are latched, grant_id is set to i, and the state goes to DRAW.
REQ-008 DRAW emits one pixel per cycle on cycles N+1 .. N+P, with P=(w+1)*(h+1).
- Raster order: x increments first, then y; first pixel is (x0,y0), last is (x0+w, y0+h).
REQ-009 plot, x, y and colour are registered outputs.
REQ-010 Clipping: a pixel whose x>=SCREEN_W or y>=SCREEN_H, or whose 9-bit sum x0+dx or y0+dy overflows 8 bits, still consumes its cycle but drives plot=0.
REQ-011 After the last pixel the state returns to IDLE at N+P+1. The earliest next accept is cycle N+P+1; there is no back-to-back accept.
REQ-012 In IDLE, plot=0; x, y and colour hold their last values.
REQ-013 clear_start=1 sets clear_pending and latches clear_colour. The request is ignored if a clear is already pending or the state is CLEAR.
REQ-014 clear_start arriving during DRAW does not abort the rectangle; the clear is taken at the next IDLE cycle.
REQ-015 clear_pending has priority over all requesters in IDLE. While it is set, req_ready=0.
REQ-016 Clear entry: IDLE with clear_pending at cycle M moves to CLEAR and clears clear_pending.
- Pixels (0,0)..(159,119) in raster order on cycles M+1 .. M+19200, plot=1, colour=latched clear colour.
REQ-017 clear_done=1 for exactly one cycle: M+19201, the first IDLE cycle after the clear. rr_ptr is unchanged by a clear.
REQ-018 clear_start and req_valid both high in the same IDLE cycle: the clear wins and no requester is accepted that cycle.
REQ-019 Requesters hold req_valid and operands until req_ready. Dropping req_valid before req_ready is legal and has no effect.
REQ-020 busy = (state != IDLE).

Reset
REQ-021 On reset (any state, including mid-DRAW or mid-CLEAR), on the next edge:
- state=IDLE, rr_ptr=0, clear_pending=0.
- plot=0, x=0, y=0, colour=0.
- clear_done=0, busy=0, grant_id=0, req_ready=0.
REQ-022 No partial rectangle or clear resumes after reset.

Verification
REQ-023 Single rect: requester 1 valid with x=5, y=110, w=15, h=1, colour=7, accepted at cycle N.
- Expect 32 plot pulses at N+1..N+32, (5,110)..(20,111), colour 7.
- busy falls at N+33.
REQ-024 Contention: all four valid continuously with rr_ptr=0.
- Expect grants in order 0,1,2,3,0; exactly one req_ready per accept.
REQ-025 Clipping: x=155, y=118, w=7, h=3.
- Expect 32 DRAW cycles; plot=1 only for x 155..159 and y 118..119 (10 pixels).
REQ-026 Clear during draw: clear_start with colour=4 mid-rectangle, requester 2 also valid.
- Rectangle completes, then CLEAR runs 19200 cycles, then clear_done pulses, then requester 2 is accepted.
REQ-027 Reset mid-CLEAR at pixel 5000.
- Next cycle: plot=0, busy=0, clear_done never pulses.
- A subsequent request from requester 0 is granted first.
